adc_frame_tx: RTL and testbench

Transmit end of the 4-bit nibble link that the oven's ADC receiver consumes (data[3:0] plus adc_int strobe). On a send request it snapshots current_temp, set_temp and set_time and serialises them as a 5-nibble frame. Each nibble is framed by an adc_int high pulse with fixed setup and hold. Used as the sensor/panel emulator driving the oven board's link and as the bench stimulus source for the receiver.

---
 rtl/adc_frame_tx_pkg.sv | 42 ++++
 rtl/adc_frame_tx_if.sv | 21 ++
 rtl/adc_frame_tx_mux.sv | 22 ++
 rtl/adc_frame_tx.sv | 102 ++++++++++
 tb/tb_adc_frame_tx.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/adc_frame_tx_pkg.sv
// Shared types and constants for the ADC nibble-link transmitter.
package adc_frame_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_GAP    = 3'd4
    } state_t;

    localparam int unsigned FRAME_NIBBLES = 5;

    localparam logic [2:0] NIB_CUR_HI = 3'd0;
    localparam logic [2:0] NIB_CUR_LO = 3'd1;
    localparam logic [2:0] NIB_SET_HI = 3'd2;
    localparam logic [2:0] NIB_SET_LO = 3'd3;
    localparam logic [2:0] NIB_TIME   = 3'd4;

    localparam int unsigned DEF_SETUP_CYC  = 2;
    localparam int unsigned DEF_STROBE_CYC = 4;
    localparam int unsigned DEF_HOLD_CYC   = 2;
    localparam int unsigned DEF_GAP_CYC    = 16;

    typedef struct packed {
        logic [7:0] current_temp;
        logic [7:0] set_temp;
        logic [3:0] set_time;
    } snapshot_t;

    // Bits needed to hold the largest phase length minus one (at least 1).
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/adc_frame_tx_if.sv
// Request side and nibble-link side of the frame transmitter.
interface adc_frame_tx_if;
    logic       send;
    logic [7:0] current_temp;
    logic [7:0] set_temp;
    logic [3:0] set_time;
    logic [3:0] data;
    logic       adc_int;
    logic       busy;
    logic       done;

    modport master (
        output send, current_temp, set_temp, set_time,
        input  data, adc_int, busy, done
    );

    modport slave (
        input  send, current_temp, set_temp, set_time,
        output data, adc_int, busy, done
    );
endinterface

// File: rtl/adc_frame_tx_mux.sv
// Selects the nibble for a frame position from the captured snapshot.
module adc_frame_mux
    import adc_frame_tx_pkg::*;
(
    input  snapshot_t  snap,
    input  logic [2:0] index,
    output logic [3:0] nibble
);

    always_comb begin
        nibble = '0;
        case (index)
            NIB_CUR_HI: nibble = snap.current_temp[7:4];
            NIB_CUR_LO: nibble = snap.current_temp[3:0];
            NIB_SET_HI: nibble = snap.set_temp[7:4];
            NIB_SET_LO: nibble = snap.set_temp[3:0];
            NIB_TIME:   nibble = snap.set_time;
            default:    nibble = '0;
        endcase
    end

endmodule

// File: rtl/adc_frame_tx.sv
// Serialises a temperature/setpoint/timer snapshot as a 5-nibble strobed frame.
// state  | meaning
// IDLE   | waiting for send, outputs quiet
// SETUP  | nibble driven, strobe low
// STROBE | strobe high, nibble held
// HOLD   | strobe low, nibble held
// GAP    | data zero, receiver resync window before done
module adc_frame_tx
    import adc_frame_tx_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = DEF_SETUP_CYC,
    parameter int unsigned STROBE_CYC = DEF_STROBE_CYC,
    parameter int unsigned HOLD_CYC   = DEF_HOLD_CYC,
    parameter int unsigned GAP_CYC    = DEF_GAP_CYC
) (
    input logic           clk,
    input logic           rst,
    adc_frame_tx_if.slave link
);

    localparam int unsigned CW = cnt_width(SETUP_CYC, STROBE_CYC, HOLD_CYC, GAP_CYC);
    localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYC - 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [2:0]    index, index_n;
    snapshot_t     snap, snap_n;
    logic [3:0]    nibble;
    logic [3:0]    data_d;
    logic          adc_int_d, busy_d, done_d;

    // Mux looks at the next snapshot so nibble 0 is ready on the accept edge.
    adc_frame_mux u_mux (
        .snap   (snap_n),
        .index  (index_n),
        .nibble (nibble)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            index        <= '0;
            snap         <= '0;
            link.data    <= '0;
            link.adc_int <= 1'b0;
            link.busy    <= 1'b0;
            link.done    <= 1'b0;
        end else begin
            state        <= state_n;
            index        <= index_n;
            snap         <= snap_n;
            cnt          <= (state_n != state || state == ST_IDLE) ? '0 : cnt + 1'b1;
            link.data    <= data_d;
            link.adc_int <= adc_int_d;
            link.busy    <= busy_d;
            link.done    <= done_d;
        end
    end

    always_comb begin
        state_n = state;
        index_n = index;
        snap_n  = snap;
        case (state)
            ST_IDLE: begin
                if (link.send) begin
                    state_n = ST_SETUP;
                    index_n = '0;
                    snap_n  = '{current_temp: link.current_temp,
                                set_temp:     link.set_temp,
                                set_time:     link.set_time};
                end
            end
            ST_SETUP:  if (cnt == SETUP_LAST)  state_n = ST_STROBE;
            ST_STROBE: if (cnt == STROBE_LAST) state_n = ST_HOLD;
            ST_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    index_n = index + 3'd1;
                    state_n = (index == NIB_TIME) ? ST_GAP : ST_SETUP;
                end
            end
            ST_GAP:    if (cnt == GAP_LAST)    state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        data_d    = '0;
        adc_int_d = 1'b0;
        busy_d    = (state_n != ST_IDLE);
        done_d    = (state == ST_GAP) && (state_n == ST_IDLE);
        if (state_n == ST_SETUP || state_n == ST_STROBE || state_n == ST_HOLD)
            data_d = nibble;
        if (state_n == ST_STROBE)
            adc_int_d = 1'b1;
    end

endmodule

// File: tb/tb_adc_frame_tx.sv
// Directed checks of the nibble-link transmitter waveform, snapshot, back-to-back and reset.
module tb_adc_frame_tx;

    localparam int SU = 2;
    localparam int SB = 4;
    localparam int HD = 2;
    localparam int GP = 16;
    localparam int NL = SU + SB + HD;
    localparam int DONE_K = 5 * NL + GP;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adc_frame_tx_if link();

    adc_frame_tx #(
        .SETUP_CYC  (SU),
        .STROBE_CYC (SB),
        .HOLD_CYC   (HD),
        .GAP_CYC    (GP)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .link (link.slave)
    );

    int errors = 0;
    int checks = 0;

    // Receiver stand-in: latch data on each strobe rising edge.
    logic [3:0] rx_q[$];
    always @(posedge link.adc_int) rx_q.push_back(link.data);

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [6:0] obs();
        return {link.busy, link.done, link.adc_int, link.data};
    endfunction

    // Expected {busy, done, adc_int, data} k cycles after the accept edge.
    function automatic logic [6:0] exp_out(input int k, input logic [19:0] nibs);
        int n, p;
        if (k < 5 * NL) begin
            n = k / NL;
            p = k % NL;
            return {1'b1, 1'b0, (p >= SU && p < SU + SB), nibs[19 - 4 * n -: 4]};
        end
        if (k < DONE_K) return {1'b1, 1'b0, 1'b0, 4'h0};
        if (k == DONE_K) return {1'b0, 1'b1, 1'b0, 4'h0};
        return 7'h00;
    endfunction

    task automatic start_frame(input logic [7:0] ct, input logic [7:0] st, input logic [3:0] tm);
        link.current_temp = ct;
        link.set_temp     = st;
        link.set_time     = tm;
        link.send         = 1'b1;
        @(negedge clk);
    endtask

    task automatic watch(input logic [19:0] nibs, input int k_last, input bit keep_send,
                         input bit poke, input string tag);
        for (int k = 0; k <= k_last; k++) begin
            check_eq($sformatf("%s k=%0d", tag, k), {9'd0, obs()}, {9'd0, exp_out(k, nibs)});
            if (k == 0 && !keep_send) link.send = 1'b0;
            if (poke && k == 10) begin
                link.current_temp = 8'hFF;
                link.send = 1'b1;
            end
            if (poke && k == 11) link.send = 1'b0;
            if (k < k_last) @(negedge clk);
        end
    endtask

    task automatic rx_check(input string tag, input int base, input logic [19:0] exp);
        logic [19:0] got;
        got = '0;
        check_eq({tag, " count"}, 16'(rx_q.size() - base), 16'd5);
        for (int i = 0; i < 5; i++) got = {got[15:0], rx_q[base + i]};
        check_eq({tag, " hi"}, {4'd0, got[19:8]}, {4'd0, exp[19:8]});
        check_eq({tag, " lo"}, {8'd0, got[7:0]}, {8'd0, exp[7:0]});
    endtask

    initial begin
        int base;
        logic [19:0] got;
        link.send = 1'b0;
        link.current_temp = '0;
        link.set_temp = '0;
        link.set_time = '0;

        repeat (3) @(negedge clk);
        check_eq("in reset", {9'd0, obs()}, 16'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle after reset", {9'd0, obs()}, 16'd0);

        base = rx_q.size();
        start_frame(8'h5C, 8'h64, 4'h9);
        watch(20'h5C649, DONE_K + 1, 1'b0, 1'b0, "basic");
        rx_check("basic rx", base, 20'h5C649);

        base = rx_q.size();
        start_frame(8'h10, 8'h22, 4'h7);
        watch(20'h10227, DONE_K + 1, 1'b0, 1'b1, "snap");
        rx_check("snap rx", base, 20'h10227);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq($sformatf("no second frame %0d", i), {15'd0, link.busy}, 16'd0);
        end

        start_frame(8'hA3, 8'hB4, 4'hC);
        watch(20'hA3B4C, DONE_K, 1'b1, 1'b0, "cont1");
        @(negedge clk);
        watch(20'hA3B4C, DONE_K + 1, 1'b0, 1'b0, "cont2");

        start_frame(8'h12, 8'h34, 4'h5);
        watch(20'h12345, 2 * NL + SU + 1, 1'b0, 1'b0, "pre-rst");
        #2 rst = 1'b1;
        #1 check_eq("async reset", {9'd0, obs()}, 16'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq($sformatf("quiet after reset %0d", i), {9'd0, obs()}, 16'd0);
        end
        base = rx_q.size();
        start_frame(8'hAB, 8'hCD, 4'h3);
        watch(20'hABCD3, DONE_K + 1, 1'b0, 1'b0, "fresh");
        rx_check("fresh rx", base, 20'hABCD3);

        base = rx_q.size();
        start_frame(8'h7A, 8'h80, 4'h5);
        watch(20'h7A805, DONE_K + 1, 1'b0, 1'b0, "loop");
        got = '0;
        for (int i = 0; i < 5; i++) got = {got[15:0], rx_q[base + i]};
        check_eq("loop current_temp", {8'd0, got[19:12]}, 16'h007A);
        check_eq("loop set_temp", {8'd0, got[11:4]}, 16'h0080);
        check_eq("loop set_time", {12'd0, got[3:0]}, 16'h0005);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
